// File: rtl/complex_sample_pairer.sv
// complex_sample_pairer
//   Buffers one half-frame of real samples, then pairs each incoming imaginary
//   sample with the stored real sample of the same index and emits the complex
//   pair on a single AXI-Stream output.
//
//   Ports:
//     clk, rst                         clock, asynchronous active-high reset
//     s_real_*                         real-sample AXIS input (accepted in FILL)
//     s_imag_*                         imaginary-sample AXIS input (accepted in PAIR)
//     m_cplx_tdata/tvalid/tready/tlast complex output, {real, imag}
//     m_cplx_index                     sample index of the presented pair
//     err_len                          one-cycle pulse on frame-length/tlast mismatch
//     frame_count, err_count           statistics counters
//
//   Optional feature: define PAIRER_STATS_EN to build the statistics counters.
//   Without it both counters are tied to zero.
module complex_sample_pairer #(
  parameter int N_SAMPLES = 512,
  parameter int DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_real_tdata,
  input  logic                s_real_tvalid,
  output logic                s_real_tready,
  input  logic                s_real_tlast,
  input  logic [DATA_W-1:0]   s_imag_tdata,
  input  logic                s_imag_tvalid,
  output logic                s_imag_tready,
  input  logic                s_imag_tlast,
  output logic [2*DATA_W-1:0] m_cplx_tdata,
  output logic                m_cplx_tvalid,
  input  logic                m_cplx_tready,
  output logic                m_cplx_tlast,
  output logic [9:0]          m_cplx_index,
  output logic                err_len,
  output logic [15:0]         frame_count,
  output logic [15:0]         err_count
);

  localparam int         AW       = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [9:0] LAST_IDX = 10'(N_SAMPLES - 1);
  localparam logic [10:0] FULL_LEN = 11'(N_SAMPLES);

  typedef enum logic {FILL, PAIR} state_t;

  state_t             state;
  logic [9:0]         wr_idx;
  logic [9:0]         rd_idx;
  logic [10:0]        len;
  logic [DATA_W-1:0]  buffer [N_SAMPLES];

  logic real_fire;
  logic imag_fire;
  logic out_fire;
  logic wr_at_max;
  logic rd_at_end;

  // The imag side is a one-stage pipeline: it may advance whenever the output
  // register is empty or being drained this cycle.
  assign s_real_tready = (state == FILL);
  assign s_imag_tready = (state == PAIR) && (!m_cplx_tvalid || m_cplx_tready);

  assign real_fire = s_real_tvalid && s_real_tready;
  assign imag_fire = s_imag_tvalid && s_imag_tready;
  assign out_fire  = m_cplx_tvalid && m_cplx_tready;
  assign wr_at_max = (wr_idx == LAST_IDX);
  assign rd_at_end = ({1'b0, rd_idx} == (len - 11'd1));

  // Sample storage has no reset; a discarded partial frame is simply
  // overwritten by the next one.
  always_ff @(posedge clk) begin
    if (real_fire) begin
      buffer[wr_idx[AW-1:0]] <= s_real_tdata;
    end
  end

  // Frame control and the registered output stage. The pair is captured into
  // the output register on the imag handshake, so the next frame may start
  // filling the buffer while the final pair of this frame is still stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FILL;
      wr_idx        <= '0;
      rd_idx        <= '0;
      len           <= FULL_LEN;
      m_cplx_tvalid <= 1'b0;
      m_cplx_tdata  <= '0;
      m_cplx_tlast  <= 1'b0;
      m_cplx_index  <= '0;
      err_len       <= 1'b0;
    end else begin
      err_len <= 1'b0;

      if (imag_fire) begin
        m_cplx_tvalid <= 1'b1;
        m_cplx_tdata  <= {buffer[rd_idx[AW-1:0]], s_imag_tdata};
        m_cplx_index  <= rd_idx;
        m_cplx_tlast  <= rd_at_end;
      end else if (out_fire) begin
        m_cplx_tvalid <= 1'b0;
      end

      case (state)
        FILL: begin
          if (real_fire) begin
            // A frame ends on tlast or a full buffer; a disagreement between
            // the two is flagged but the frame still proceeds.
            if (s_real_tlast || wr_at_max) begin
              state   <= PAIR;
              len     <= {1'b0, wr_idx} + 11'd1;
              wr_idx  <= '0;
              rd_idx  <= '0;
              err_len <= (s_real_tlast != wr_at_max);
            end else begin
              wr_idx <= wr_idx + 10'd1;
            end
          end
        end
        PAIR: begin
          if (imag_fire) begin
            // Imag tlast is only checked, never used to end the frame.
            err_len <= (s_imag_tlast != rd_at_end);
            if (rd_at_end) begin
              state  <= FILL;
              rd_idx <= '0;
              wr_idx <= '0;
            end else begin
              rd_idx <= rd_idx + 10'd1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef PAIRER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;

  // Saturating statistics: completed frames count on acceptance of the final
  // pair, errors count on each err_len pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (out_fire && m_cplx_tlast && (frame_cnt_q != 16'hFFFF)) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (err_len && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign frame_count = frame_cnt_q;
  assign err_count   = err_cnt_q;
`else
  assign frame_count = '0;
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_complex_sample_pairer.sv
// tb_complex_sample_pairer
//   Directed frame sequence with randomized sample data, valid gaps and output
//   ready patterns. A reference model holds the stored real samples, the queue
//   of expected complex pairs and the expected error/frame totals.
module tb_complex_sample_pairer;

  localparam int N  = 512;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [DW-1:0]   s_real_tdata;
  logic            s_real_tvalid;
  logic            s_real_tready;
  logic            s_real_tlast;
  logic [DW-1:0]   s_imag_tdata;
  logic            s_imag_tvalid;
  logic            s_imag_tready;
  logic            s_imag_tlast;
  logic [2*DW-1:0] m_cplx_tdata;
  logic            m_cplx_tvalid;
  logic            m_cplx_tready;
  logic            m_cplx_tlast;
  logic [9:0]      m_cplx_index;
  logic            err_len;
  logic [15:0]     frame_count;
  logic [15:0]     err_count;

  complex_sample_pairer #(.N_SAMPLES(N), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_real_tdata  (s_real_tdata),
    .s_real_tvalid (s_real_tvalid),
    .s_real_tready (s_real_tready),
    .s_real_tlast  (s_real_tlast),
    .s_imag_tdata  (s_imag_tdata),
    .s_imag_tvalid (s_imag_tvalid),
    .s_imag_tready (s_imag_tready),
    .s_imag_tlast  (s_imag_tlast),
    .m_cplx_tdata  (m_cplx_tdata),
    .m_cplx_tvalid (m_cplx_tvalid),
    .m_cplx_tready (m_cplx_tready),
    .m_cplx_tlast  (m_cplx_tlast),
    .m_cplx_index  (m_cplx_index),
    .err_len       (err_len),
    .frame_count   (frame_count),
    .err_count     (err_count)
  );

  typedef struct {
    logic [2*DW-1:0] data;
    logic [9:0]      idx;
    logic            last;
  } pair_t;

  int          compared   = 0;
  int          mismatched = 0;
  int          errSeen    = 0;
  int          errExp     = 0;
  int          framesExp  = 0;
  int          statErrExp = 0;
  logic [DW-1:0] refBuf [N];
  pair_t       expQ [$];

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts err_len pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (err_len === 1'b1) errSeen++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst           = 1'b1;
    s_real_tvalid = 1'b0;
    s_real_tlast  = 1'b0;
    s_imag_tvalid = 1'b0;
    s_imag_tlast  = 1'b0;
    m_cplx_tready = 1'b0;
    #2;
    checkOutput("rst_tvalid", 64'(m_cplx_tvalid), 64'd0);
    checkOutput("rst_tdata", m_cplx_tdata, 64'd0);
    checkOutput("rst_tlast", 64'(m_cplx_tlast), 64'd0);
    checkOutput("rst_index", 64'(m_cplx_index), 64'd0);
    checkOutput("rst_err_len", 64'(err_len), 64'd0);
    checkOutput("rst_frame_count", 64'(frame_count), 64'd0);
    checkOutput("rst_err_count", 64'(err_count), 64'd0);
    expQ.delete();
    framesExp  = 0;
    statErrExp = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_real_tready", 64'(s_real_tready), 64'd1);
    checkOutput("post_rst_imag_tready", 64'(s_imag_tready), 64'd0);
    stepEdge();
  endtask

  // Feeds one frame of reals; n beats, tlast optionally on the last one.
  task automatic sendReals(input int n, input bit withTlast, input bit randData);
    for (int i = 0; i < n; i++) begin
      if (randData && ($urandom_range(0, 7) == 0)) begin
        s_real_tvalid = 1'b0;
        stepEdge();
      end
      s_real_tvalid = 1'b1;
      s_real_tdata  = randData ? DW'($urandom) : DW'(i);
      s_real_tlast  = withTlast && (i == n - 1);
      @(negedge clk);
      if (i == 0 || i == n - 1) begin
        checkOutput("real_tready", 64'(s_real_tready), 64'd1);
        if (expQ.size() > 0) begin
          checkOutput("tail_hold_tvalid", 64'(m_cplx_tvalid), 64'd1);
          checkOutput("tail_hold_tdata", m_cplx_tdata, expQ[0].data);
          checkOutput("tail_hold_index", 64'(m_cplx_index), 64'(expQ[0].idx));
        end
      end
      @(posedge clk);
      refBuf[i] = s_real_tdata;
      #1;
    end
    s_real_tvalid = 1'b0;
    s_real_tlast  = 1'b0;
    if (withTlast != (n == N)) begin
      errExp++;
      statErrExp++;
    end
  endtask

  // Feeds the imag half of a frame and checks every output pair.
  // readyMode: 0 always ready, 1 toggling, 2 random. abortAt>=0 stops feeding
  // once that index is reached; leaveTail leaves the final pair stalled.
  task automatic applyStimulus(input int len, input int earlyAt, input int readyMode,
                               input int abortAt, input bit leaveTail, input bit randData);
    int    sent;
    int    cycles;
    int    budget;
    bit    expReady;
    bit    startEmpty;
    pair_t p;
    sent       = 0;
    cycles     = 0;
    budget     = 40 * len + 200;
    startEmpty = (expQ.size() == 0);
    while (!(sent == len && (expQ.size() == 0 || leaveTail)) && cycles < budget) begin
      if (sent == abortAt) break;
      cycles++;
      s_imag_tvalid = (sent < len) && (readyMode == 0 || $urandom_range(0, 5) != 0);
      s_imag_tdata  = randData ? DW'($urandom) : DW'(32'h1000 + sent);
      s_imag_tlast  = (sent == len - 1) || (sent == earlyAt);
      m_cplx_tready = (readyMode == 0) ? 1'b1 :
                      (readyMode == 1) ? cycles[0] : 1'($urandom_range(0, 1));
      @(negedge clk);
      expReady = (sent < len) && (expQ.size() == 0 || m_cplx_tready);
      checkOutput("imag_tready", 64'(s_imag_tready), 64'(expReady));
      checkOutput("cplx_tvalid", 64'(m_cplx_tvalid), 64'(expQ.size() > 0));
      if (expQ.size() > 0) begin
        checkOutput("cplx_tdata", m_cplx_tdata, expQ[0].data);
        checkOutput("cplx_index", 64'(m_cplx_index), 64'(expQ[0].idx));
        checkOutput("cplx_tlast", 64'(m_cplx_tlast), 64'(expQ[0].last));
        if (m_cplx_tready) begin
          if (expQ[0].last) framesExp++;
          void'(expQ.pop_front());
        end
      end
      @(posedge clk);
      if (s_imag_tvalid && expReady) begin
        p.data = {refBuf[sent], s_imag_tdata};
        p.idx  = 10'(sent);
        p.last = (sent == len - 1);
        expQ.push_back(p);
        if (s_imag_tlast != (sent == len - 1)) begin
          errExp++;
          statErrExp++;
        end
        sent++;
      end
      #1;
    end
    s_imag_tvalid = 1'b0;
    s_imag_tlast  = 1'b0;
    if (leaveTail) m_cplx_tready = 1'b0;
    compared++;
    assert (cycles < budget) else begin
      mismatched++;
      $error("[TB] FAIL imag_timeout observed=%0d expected=<%0d", cycles, budget);
    end
    if (readyMode == 0 && abortAt < 0 && !leaveTail && startEmpty) begin
      checkOutput("no_bubble_cycles", 64'(cycles), 64'(len + 1));
    end
  endtask

  task automatic checkStats();
    repeat (2) stepEdge();
    checkOutput("err_len_pulses", 64'(errSeen), 64'(errExp));
`ifdef PAIRER_STATS_EN
    checkOutput("frame_count", 64'(frame_count), 64'(framesExp));
    checkOutput("err_count", 64'(err_count), 64'(statErrExp));
`else
    checkOutput("frame_count_off", 64'(frame_count), 64'd0);
    checkOutput("err_count_off", 64'(err_count), 64'd0);
`endif
  endtask

  initial begin
    rst           = 1'b1;
    s_real_tdata  = '0;
    s_real_tvalid = 1'b0;
    s_real_tlast  = 1'b0;
    s_imag_tdata  = '0;
    s_imag_tvalid = 1'b0;
    s_imag_tlast  = 1'b0;
    m_cplx_tready = 1'b0;
    applyReset();

    $display("[TB] nominal frame");
    sendReals(N, 1'b1, 1'b0);
    applyStimulus(N, -1, 0, -1, 1'b0, 1'b0);
    checkStats();

    $display("[TB] toggling backpressure");
    sendReals(N, 1'b1, 1'b1);
    applyStimulus(N, -1, 1, -1, 1'b0, 1'b1);
    checkStats();

    $display("[TB] short frame");
    sendReals(100, 1'b1, 1'b1);
    applyStimulus(100, -1, 2, -1, 1'b0, 1'b1);
    checkStats();
    @(negedge clk);
    checkOutput("short_back_fill_real", 64'(s_real_tready), 64'd1);
    checkOutput("short_back_fill_imag", 64'(s_imag_tready), 64'd0);
    stepEdge();

    $display("[TB] early imag tlast");
    sendReals(N, 1'b1, 1'b1);
    applyStimulus(N, 10, 2, -1, 1'b0, 1'b1);
    checkStats();

    $display("[TB] missing real tlast, stalled tail overlapping next fill");
    sendReals(N, 1'b0, 1'b1);
    applyStimulus(N, -1, 2, -1, 1'b1, 1'b1);
    sendReals(N, 1'b1, 1'b1);
    applyStimulus(N, -1, 0, -1, 1'b0, 1'b1);
    checkStats();

    $display("[TB] reset mid-frame");
    sendReals(N, 1'b1, 1'b1);
    applyStimulus(N, -1, 0, 200, 1'b0, 1'b1);
    applyReset();
    sendReals(N, 1'b1, 1'b1);
    applyStimulus(N, -1, 2, -1, 1'b0, 1'b1);
    checkStats();

    $display("[TB] statistics run");
    applyReset();
    for (int f = 0; f < 3; f++) begin
      sendReals(N, 1'b1, 1'b1);
      applyStimulus(N, -1, 2, -1, 1'b0, 1'b1);
    end
    sendReals(100, 1'b1, 1'b1);
    applyStimulus(100, -1, 0, -1, 1'b0, 1'b1);
    checkStats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
